three_input_nor_gate_a_blk: RTL and testbench

THREE_INPUT_NOR_GATE_A_BLK -- requirements
Module: three_input_nor_gate_a

---
 rtl/three_input_nor_gate_a_blk.sv | 50 +++++
 tb/tb_three_input_nor_gate_a_blk.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/three_input_nor_gate_a_blk.sv
// rtl/three_input_nor_gate_a_blk.sv - bitwise three-input NOR with optional registered output
// REG_OUT selects a clocked result register with capture enable, or a pure combinational path.
module three_input_nor_gate_a_blk #(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             d_valid
);

  logic [WIDTH-1:0] n;

  assign n = ~(a | b | c);

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [WIDTH-1:0] d_q;
      logic             d_valid_q;

      // d_valid flags only a fresh capture; a held value is reported as stale.
      always_ff @(posedge clk) begin
        if (rst) begin
          d_q       <= '0;
          d_valid_q <= 1'b0;
        end else if (en) begin
          d_q       <= n;
          d_valid_q <= 1'b1;
        end else begin
          d_valid_q <= 1'b0;
        end
      end

      assign d       = d_q;
      assign d_valid = d_valid_q;
    end else begin : g_comb
      logic unused_ok;

      assign unused_ok = &{1'b0, clk, rst};
      assign d         = n;
      assign d_valid   = en;
    end
  endgenerate

endmodule

// File: tb/tb_three_input_nor_gate_a_blk.sv
// tb/tb_three_input_nor_gate_a_blk.sv - self-checking bench for three_input_nor_gate_a_blk
// Covers registered WIDTH=1/WIDTH=8 instances and a combinational instance.
module tb_three_input_nor_gate_a_blk;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       a1, b1, c1;
  logic       d1, v1;
  logic [7:0] a8, b8, c8;
  logic [7:0] d8;
  logic       v8;
  logic       en_c, a_c, b_c, c_c;
  logic       d_c, v_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  three_input_nor_gate_a_blk #(.WIDTH(1), .REG_OUT(1)) u_w1 (
    .clk(clk), .rst(rst), .en(en), .a(a1), .b(b1), .c(c1), .d(d1), .d_valid(v1)
  );

  three_input_nor_gate_a_blk #(.WIDTH(8), .REG_OUT(1)) u_w8 (
    .clk(clk), .rst(rst), .en(en), .a(a8), .b(b8), .c(c8), .d(d8), .d_valid(v8)
  );

  three_input_nor_gate_a_blk #(.WIDTH(1), .REG_OUT(0)) u_comb (
    .clk(clk), .rst(rst), .en(en_c), .a(a_c), .b(b_c), .c(c_c), .d(d_c), .d_valid(v_c)
  );

  typedef struct {
    logic [2:0] abc;
    logic       d_exp;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d_exp;
  } vec8_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec1_t sweep[8];
  vec8_t v8tab[4];

  initial begin
    sweep[0] = '{3'b000, 1'b1};
    sweep[1] = '{3'b001, 1'b0};
    sweep[2] = '{3'b010, 1'b0};
    sweep[3] = '{3'b011, 1'b0};
    sweep[4] = '{3'b100, 1'b0};
    sweep[5] = '{3'b101, 1'b0};
    sweep[6] = '{3'b110, 1'b0};
    sweep[7] = '{3'b111, 1'b0};
    v8tab[0] = '{8'h0F, 8'h30, 8'h80, 8'h40};
    v8tab[1] = '{8'h00, 8'h00, 8'h00, 8'hFF};
    v8tab[2] = '{8'hFF, 8'h00, 8'h00, 8'h00};
    v8tab[3] = '{8'h01, 8'h02, 8'h04, 8'hF8};

    rst = 1'b1; en = 1'b1;
    {a1, b1, c1} = 3'b111;
    a8 = 8'hFF; b8 = 8'h00; c8 = 8'h00;
    en_c = 1'b0; a_c = 1'b0; b_c = 1'b0; c_c = 1'b0;

    // Reset state: regardless of en and inputs.
    tick();
    check("reset_d1", 64'(d1), 64'd0);
    check("reset_v1", 64'(v1), 64'd0);
    check("reset_d8", 64'(d8), 64'd0);
    check("reset_v8", 64'(v8), 64'd0);

    // Exhaustive single-bit sweep, one combination per cycle.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = sweep[i].abc;
      tick();
      check($sformatf("sweep_d_%0d", i), 64'(d1), 64'(sweep[i].d_exp));
      check($sformatf("sweep_v_%0d", i), 64'(v1), 64'd1);
    end

    // Eight-bit vectors, one cycle latency.
    for (int i = 0; i < 4; i++) begin
      a8 = v8tab[i].a; b8 = v8tab[i].b; c8 = v8tab[i].c;
      tick();
      check($sformatf("vec8_d_%0d", i), 64'(d8), 64'(v8tab[i].d_exp));
      check($sformatf("vec8_v_%0d", i), 64'(v8), 64'd1);
    end

    // Reset with abc=000, then release: capture on first edge.
    rst = 1'b1; en = 1'b1; {a1, b1, c1} = 3'b000;
    tick();
    check("rst_hold_d", 64'(d1), 64'd0);
    check("rst_hold_v", 64'(v1), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_release_d", 64'(d1), 64'd1);
    check("rst_release_v", 64'(v1), 64'd1);

    // Inputs changing between edges must not disturb d.
    {a1, b1, c1} = 3'b111;
    #3;
    check("between_edges_d", 64'(d1), 64'd1);

    // Enable hold.
    {a1, b1, c1} = 3'b000;
    tick();
    check("hold_cap_d", 64'(d1), 64'd1);
    en = 1'b0; {a1, b1, c1} = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_d_%0d", i), 64'(d1), 64'd1);
      check($sformatf("hold_v_%0d", i), 64'(v1), 64'd0);
    end
    en = 1'b1;
    tick();
    check("hold_resume_d", 64'(d1), 64'd0);
    check("hold_resume_v", 64'(v1), 64'd1);

    // Reset wins over enable in mid operation; capture resumes the edge after.
    {a1, b1, c1} = 3'b000;
    tick();
    check("mid_pre_d", 64'(d1), 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_d", 64'(d1), 64'd0);
    check("mid_rst_v", 64'(v1), 64'd0);
    check("mid_rst_d8", 64'(d8), 64'd0);
    rst = 1'b0;
    tick();
    check("mid_after_d", 64'(d1), 64'd1);
    check("mid_after_v", 64'(v1), 64'd1);

    // Combinational instance: c every 100 ns, b every 200 ns, a every 400 ns.
    for (int t = 0; t <= 8; t++) begin
      {a_c, b_c, c_c} = 3'(t % 8);
      en_c = t[0];
      #1;
      check($sformatf("comb_d_%0d", t), 64'(d_c), (t == 0 || t == 8) ? 64'd1 : 64'd0);
      check($sformatf("comb_v_%0d", t), 64'(v_c), 64'(t[0]));
      #48;
      check($sformatf("comb_mid_d_%0d", t), 64'(d_c), (t == 0 || t == 8) ? 64'd1 : 64'd0);
      #51;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
